// File: rtl/add_issue_ctrl.sv
// add_issue_ctrl
//   Operand-issue and result-capture stage around a non-stallable,
//   fixed-latency pipelined adder. Operand pairs enter through a valid/ready
//   operand FIFO. An operand pair is issued to the adder only when a result
//   slot is guaranteed, so that every sum has a place when it arrives. Sums
//   are captured into a result FIFO and returned in acceptance order.
//
// Optional feature (macro ADD_ISSUE_TAG_EN):
//   Adds a 4-bit tag (in_tag / out_tag). The tag travels with its operands
//   and its result.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   operand FIFO can accept (held low while in reset)
//   in_a/in_b  operands
//   in_tag     (ADD_ISSUE_TAG_EN) tag stored with the operand pair
//   add_a/b    registered operands driven to the adder
//   add_sum    adder sum, valid ADD_LAT edges after add_a/add_b update
//   out_valid  result FIFO non-empty
//   out_ready  consumer accepts the head result
//   out_sum    head of the result FIFO (0 when empty)
//   out_tag    (ADD_ISSUE_TAG_EN) tag of the head result (0 when empty)
//   busy       an operand is buffered, an add is in flight, or a result is held
module add_issue_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADD_LAT = 3,
  parameter int ODEPTH  = 4,
  parameter int RDEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
`ifdef ADD_ISSUE_TAG_EN
  input  logic [3:0]        in_tag,
  output logic [3:0]        out_tag,
`endif
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  input  logic [DATA_W-1:0] add_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              busy
);

  localparam int OAW = $clog2(ODEPTH);
  localparam int RAW = $clog2(RDEPTH);
  localparam int VS  = ADD_LAT + 1;        // valid-pipe stages
  localparam int IFW = $clog2(VS + 1);     // inflight counter width
  localparam int CW  = RAW + 2;            // credit arithmetic width

  localparam logic [OAW:0]   OP_ONE  = 1;
  localparam logic [RAW:0]   RES_ONE = 1;
  localparam logic [IFW-1:0] IF_ONE  = 1;

  // Operand FIFO
  logic [DATA_W-1:0] op_a_mem [ODEPTH];
  logic [DATA_W-1:0] op_b_mem [ODEPTH];
  logic [OAW:0]      op_wr;
  logic [OAW:0]      op_rd;
  logic              op_empty;
  logic              op_full;
  logic [DATA_W-1:0] op_a_head;
  logic [DATA_W-1:0] op_b_head;

  // Result FIFO
  logic [DATA_W-1:0] res_mem [RDEPTH];
  logic [RAW:0]      res_wr;
  logic [RAW:0]      res_rd;
  logic [RAW:0]      res_count;

  // Issue tracking
  logic [VS-1:0]     vld_p;
  logic [IFW-1:0]    inflight;
  logic [CW-1:0]     credit_used;

  logic push;
  logic issue;
  logic capture;
  logic pop;

  assign op_empty  = (op_wr == op_rd);
  assign op_full   = (op_wr[OAW] != op_rd[OAW]) &&
                     (op_wr[OAW-1:0] == op_rd[OAW-1:0]);
  assign op_a_head = op_a_mem[op_rd[OAW-1:0]];
  assign op_b_head = op_b_mem[op_rd[OAW-1:0]];

  // in_ready looks only at registered fullness: a slot freed by an issue
  // this cycle is not offered until the next cycle.
  assign in_ready  = rst_n && !op_full;
  assign push      = in_valid && in_ready;

  assign res_count = res_wr - res_rd;
  assign out_valid = (res_wr != res_rd);
  assign pop       = out_valid && out_ready;

  // Every in-flight add and every held result owns one result-FIFO slot.
  // Registered counts only, so a pop returns its credit one cycle later.
  assign credit_used = CW'(inflight) + CW'(res_count);
  assign issue       = !op_empty && (credit_used < CW'(RDEPTH));
  assign capture     = vld_p[VS-1];

  assign out_sum = out_valid ? res_mem[res_rd[RAW-1:0]] : '0;
  assign busy    = !op_empty || (inflight != '0) || out_valid;

  // Stage p0: operand storage
  always_ff @(posedge clk) begin
    if (push) begin
      op_a_mem[op_wr[OAW-1:0]] <= in_a;
      op_b_mem[op_wr[OAW-1:0]] <= in_b;
    end
  end

  // Stage p1..pN: issue, adder tracking, capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_wr    <= '0;
      op_rd    <= '0;
      res_wr   <= '0;
      res_rd   <= '0;
      vld_p    <= '0;
      inflight <= '0;
      add_a    <= '0;
      add_b    <= '0;
    end else begin
      if (push) op_wr <= op_wr + OP_ONE;
      if (issue) begin
        op_rd <= op_rd + OP_ONE;
        add_a <= op_a_head;
        add_b <= op_b_head;
      end
      vld_p <= {vld_p[VS-2:0], issue};
      case ({issue, capture})
        2'b10:   inflight <= inflight + IF_ONE;
        2'b01:   inflight <= inflight - IF_ONE;
        default: inflight <= inflight;
      endcase
      if (capture) res_wr <= res_wr + RES_ONE;
      if (pop)     res_rd <= res_rd + RES_ONE;
    end
  end

  // Stage capture: result storage, the credit rule keeps this from overflowing
  always_ff @(posedge clk) begin
    if (capture) res_mem[res_wr[RAW-1:0]] <= add_sum;
  end

`ifdef ADD_ISSUE_TAG_EN
  logic [3:0] op_t_mem  [ODEPTH];
  logic [3:0] tag_p     [VS];
  logic [3:0] res_t_mem [RDEPTH];

  // Tag pipe shifts every cycle in lockstep with vld_p; entries without a
  // valid bit are never captured.
  always_ff @(posedge clk) begin
    if (push) op_t_mem[op_wr[OAW-1:0]] <= in_tag;
    tag_p[0] <= op_t_mem[op_rd[OAW-1:0]];
    for (int i = 1; i < VS; i++) tag_p[i] <= tag_p[i-1];
    if (capture) res_t_mem[res_wr[RAW-1:0]] <= tag_p[VS-1];
  end

  assign out_tag = out_valid ? res_t_mem[res_rd[RAW-1:0]] : '0;
`endif

endmodule

// File: tb/tb_add_issue_ctrl.sv
// Testbench for add_issue_ctrl with an ideal ADD_LAT-edge registered adder.
module tb_add_issue_ctrl;

  localparam int ADD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        busy;
`ifdef ADD_ISSUE_TAG_EN
  logic [3:0]  in_tag;
  logic [3:0]  out_tag;
`endif

  always #5 clk = ~clk;

  add_issue_ctrl #(.DATA_W(32), .ADD_LAT(ADD_LAT), .ODEPTH(4), .RDEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef ADD_ISSUE_TAG_EN
    .in_tag    (in_tag),
    .out_tag   (out_tag),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  // Ideal adder: sum visible ADD_LAT edges after the operand registers change.
  logic [31:0] s_p [ADD_LAT];
  always @(posedge clk) begin
    s_p[0] <= add_a + add_b;
    for (int i = 1; i < ADD_LAT; i++) s_p[i] <= s_p[i-1];
  end
  assign add_sum = s_p[ADD_LAT-1];

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
  } vec_t;

  vec_t        vecs [5];
  logic [31:0] opa  [32];
  logic [31:0] opb  [32];
  logic [31:0] exps;
  int          idx, got, lat, stall, bad_t;
  logic        acc;

  initial begin
    vecs[0] = '{"single",  32'h0000_0005, 32'h0000_0003, 32'h0000_0008};
    vecs[1] = '{"wrap1",   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[2] = '{"wrap2",   32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    vecs[3] = '{"mixed",   32'h1234_5678, 32'h1111_1111, 32'h2345_6789};
    vecs[4] = '{"carry",   32'h0FFF_FFFF, 32'h0000_0001, 32'h1000_0000};

    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
`ifdef ADD_ISSUE_TAG_EN
    in_tag    = '0;
`endif
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum",   out_sum,            32'd0);
    check("rst_add_a",     add_a,              32'd0);
    check("rst_add_b",     add_b,              32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
`ifdef ADD_ISSUE_TAG_EN
    check("rst_out_tag",   {28'd0, out_tag},   32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single operations: latency, arithmetic, busy after pop
    for (int v = 0; v < 5; v++) begin
      in_a = vecs[v].a;
      in_b = vecs[v].b;
      in_valid = 1'b1;
      check({vecs[v].name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
        step();
        if (out_valid) begin
          lat = k;
          break;
        end
      end
      check({vecs[v].name, "_latency"}, lat, 32'd5);
      check({vecs[v].name, "_sum"}, out_sum, vecs[v].s);
      check({vecs[v].name, "_busy_held"}, {31'd0, busy}, 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({vecs[v].name, "_valid_after_pop"}, {31'd0, out_valid}, 32'd0);
      check({vecs[v].name, "_busy_after_pop"}, {31'd0, busy}, 32'd0);
    end

    // Backpressure: 8 results held, 4 operands buffered, then drain in order
    for (int i = 0; i < 16; i++) begin
      opa[i] = 32'h1000_0000 * i + 32'd7 * i;
      opb[i] = 32'hF000_0001 + i;
    end
    idx = 0;
    for (int k = 0; k < 30; k++) begin
      if (idx < 16) begin
        in_valid = 1'b1; in_a = opa[idx]; in_b = opb[idx];
      end else in_valid = 1'b0;
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
    end
    check("bp_accepted", idx, 32'd12);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_busy", {31'd0, busy}, 32'd1);
    out_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 80; k++) begin
      if (idx < 16) begin
        in_valid = 1'b1; in_a = opa[idx]; in_b = opb[idx];
      end else in_valid = 1'b0;
      acc = in_valid && in_ready;
      if (out_valid) begin
        if (got < 16) begin
          exps = opa[got] + opb[got];
          check("bp_sum", out_sum, exps);
        end
        got++;
      end
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_results", got, 32'd16);
    check("bp_all_accepted", idx, 32'd16);
    check("bp_idle", {31'd0, busy}, 32'd0);

    // Streaming: one accept and one result per cycle
    for (int i = 0; i < 32; i++) begin
      opa[i] = $urandom;
      opb[i] = $urandom;
    end
    got = 0; stall = 0; bad_t = 0;
    for (int k = 0; k < 60; k++) begin
      if (k < 32) begin
        in_valid = 1'b1; in_a = opa[k]; in_b = opb[k];
        if (!in_ready) stall++;
      end else in_valid = 1'b0;
      if (out_valid) begin
        if (got < 32) begin
          exps = opa[got] + opb[got];
          check("stream_sum", out_sum, exps);
          if (k != got + 6) bad_t++;
        end
        got++;
      end
      step();
    end
    in_valid = 1'b0;
    check("stream_stalls", stall, 32'd0);
    check("stream_timing", bad_t, 32'd0);
    check("stream_results", got, 32'd32);
    out_ready = 1'b0;

    // Reset with 3 adds in flight and 2 results held
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_a = k + 1; in_b = 32'd100;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    check("mid_valid_pre", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_add_a", add_a, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_a = 32'h10; in_b = 32'h20;
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) begin
        check("mid_after_sum", out_sum, 32'h30);
        got++;
      end
      step();
    end
    check("mid_after_count", got, 32'd1);
    out_ready = 1'b0;

`ifdef ADD_ISSUE_TAG_EN
    // Tags follow their sums with a toggling consumer
    begin
      logic [3:0] tags [3];
      tags[0] = 4'hA; tags[1] = 4'h3; tags[2] = 4'hF;
      idx = 0; got = 0;
      for (int k = 0; k < 40; k++) begin
        if (idx < 3) begin
          in_valid = 1'b1; in_a = 32'h100 * (idx + 1); in_b = idx; in_tag = tags[idx];
        end else in_valid = 1'b0;
        out_ready = k[0];
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
          if (got < 3) begin
            exps = 32'h100 * (got + 1) + got;
            check("tag_sum", out_sum, exps);
            check("tag_value", {28'd0, out_tag}, {28'd0, tags[got]});
          end
          got++;
        end
        step();
        if (acc) idx++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("tag_count", got, 32'd3);
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
